// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and default configuration shared by the
// sequence detector files.
package seq_det_pkg;
   typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_e;
   localparam int PAT_W_DEF = 16;
   localparam int CNT_W_DEF = 8;
   localparam logic [31:0] DEF_PAT_C = 32'h0000_005A;
   localparam int DEF_LEN_C = 7;
endpackage

// File: rtl/seq_win_reg.sv
// seq_win_reg: serial window shift register with a saturating fill counter.
// Exposes the post-shift window and fill so the comparator sees the incoming bit.
module seq_win_reg #(
   parameter int PAT_W = 16,
   parameter int LW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic             fill_clr_i,
   input  logic             bit_i,
   output logic [PAT_W-1:0] sh_win_o,
   output logic [LW-1:0]    sh_fill_o
);
   logic [PAT_W-1:0] win_q, win_d;
   logic [LW-1:0] fill_q, fill_d;
   always_comb begin
      sh_win_o = {win_q[PAT_W-2:0], bit_i};
      sh_fill_o = (fill_q == LW'(PAT_W)) ? fill_q : fill_q + 1'b1;
      win_d = clr_i ? '0 : shift_i ? sh_win_o : win_q;
      fill_d = clr_i ? '0 : !shift_i ? fill_q : fill_clr_i ? '0 : sh_fill_o;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         win_q <= '0;
         fill_q <= '0;
      end else begin
         win_q <= win_d;
         fill_q <= fill_d;
      end
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial pattern detector with masked compare and overlap control.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
   parameter int DEF_LEN = DEF_LEN_C
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       seq_in,
   input  logic                       seq_vld,
   input  logic                       cfg_load,
   input  logic [PAT_W-1:0]           cfg_pat,
   input  logic [PAT_W-1:0]           cfg_mask,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cfg_ovl,
   input  logic                       cnt_clr,
   output logic                       flag,
   output logic [CNT_W-1:0]           match_cnt
);
   localparam int LW = $clog2(PAT_W + 1);
   logic [PAT_W-1:0] pat_q, msk_q, sh_win, len_msk;
   logic [LW-1:0] len_q, len_d, sh_fill;
   logic ovl_q, flag_q, flag_d;
   state_e st_nxt;
   seq_win_reg #(.PAT_W(PAT_W), .LW(LW)) u_win (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (cfg_load),
      .shift_i   (seq_vld),
      .fill_clr_i(flag_d & ~ovl_q),
      .bit_i     (seq_in),
      .sh_win_o  (sh_win),
      .sh_fill_o (sh_fill)
   );
   // A shift by the full width yields zero, so len_q == PAT_W gives an all-ones mask.
   always_comb begin
      len_d = (cfg_len == '0 || cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
      len_msk = ~({PAT_W{1'b1}} << len_q);
      st_nxt = (sh_fill >= len_q) ? ARMED : FILL;
      flag_d = seq_vld && !cfg_load && st_nxt == ARMED && ((sh_win ^ pat_q) & msk_q & len_msk) == '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pat_q <= DEF_PAT;
         msk_q <= '1;
         len_q <= LW'(DEF_LEN);
         ovl_q <= 1'b1;
         flag_q <= 1'b0;
      end else begin
         if (cfg_load) begin
            pat_q <= cfg_pat;
            msk_q <= cfg_mask;
            len_q <= len_d;
            ovl_q <= cfg_ovl;
         end
         flag_q <= flag_d;
      end
   assign flag = flag_q;
`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = cnt_clr ? CNT_W'(flag_d) : (flag_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign match_cnt = cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt = '0;
`endif
endmodule
